// File: rtl/cob_timing_pkg.sv
// Shared constants and state encoding for the COB timing word transmitter.
// A word is a 2-bit type tag above an 8-bit payload.
package cob_timing_pkg;

   localparam int WORD_W    = 10;
   localparam int PAYLOAD_W = 8;

   localparam logic [1:0] TYPE_DATA = 2'b00;
   localparam logic [1:0] TYPE_SOF  = 2'b01;
   localparam logic [1:0] TYPE_EOF  = 2'b10;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SOF,
      ST_DATA,
      ST_EOF,
      ST_GAP
   } state_e;

   function automatic logic [WORD_W-1:0] make_word(input logic [1:0]           word_type,
                                                   input logic [PAYLOAD_W-1:0] payload);
      return {word_type, payload};
   endfunction

endpackage

// File: rtl/cob_timing_tx.sv
// Serialises one timing request into SOF, four timestamp DATA words (MSB first)
// and an EOF carrying an XOR checksum, then enforces an idle gap before the next frame.
module cob_timing_tx
   import cob_timing_pkg::*;
#(
   parameter int GAP_CYCLES = 2
) (
   input  logic                 sysClk200,
   input  logic                 sysClk200Rst,
   input  logic                 reqValid,
   output logic                 reqReady,
   input  logic [7:0]           reqOpcode,
   input  logic [31:0]          reqTimestamp,
   output logic [WORD_W-1:0]    txData,
   output logic                 txDataEn,
   input  logic                 txReady,
   output logic                 busy,
   output logic [15:0]          frameCount
);

   // Last gap count value; unused when GAP_CYCLES is zero because GAP is skipped.
   localparam logic [3:0] GAP_LAST = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;

   state_e                 state_q, state_d;
   logic [1:0]             byte_idx_q, byte_idx_d;
   logic [3:0]             gap_cnt_q, gap_cnt_d;
   logic [PAYLOAD_W-1:0]   opcode_q, opcode_d;
   logic [31:0]            ts_q, ts_d;
   logic [15:0]            frame_count_q, frame_count_d;

   logic                   accept;
   logic                   xfer;
   logic                   tx_en;
   logic [WORD_W-1:0]      tx_word;
   logic [PAYLOAD_W-1:0]   data_byte;
   logic [PAYLOAD_W-1:0]   checksum;

   // Ready is masked during reset so nothing is accepted in the reset cycle itself.
   assign reqReady   = (state_q == ST_IDLE) && !sysClk200Rst;
   assign accept     = reqValid && reqReady;
   assign xfer       = tx_en && txReady;

   assign checksum   = opcode_q ^ ts_q[31:24] ^ ts_q[23:16] ^ ts_q[15:8] ^ ts_q[7:0];

   assign txData     = tx_word;
   assign txDataEn   = tx_en;
   assign busy       = (state_q != ST_IDLE);
   assign frameCount = frame_count_q;

   always_comb begin
      data_byte = '0;
      case (byte_idx_q)
         2'd0:    data_byte = ts_q[31:24];
         2'd1:    data_byte = ts_q[23:16];
         2'd2:    data_byte = ts_q[15:8];
         default: data_byte = ts_q[7:0];
      endcase
   end

   // Outputs depend only on registered state, so they stay stable across stalls.
   always_comb begin
      tx_en   = 1'b0;
      tx_word = '0;
      case (state_q)
         ST_SOF: begin
            tx_en   = 1'b1;
            tx_word = make_word(TYPE_SOF, opcode_q);
         end
         ST_DATA: begin
            tx_en   = 1'b1;
            tx_word = make_word(TYPE_DATA, data_byte);
         end
         ST_EOF: begin
            tx_en   = 1'b1;
            tx_word = make_word(TYPE_EOF, checksum);
         end
         default: begin
            tx_en   = 1'b0;
            tx_word = '0;
         end
      endcase
   end

   always_comb begin
      state_d       = state_q;
      byte_idx_d    = byte_idx_q;
      gap_cnt_d     = gap_cnt_q;
      opcode_d      = opcode_q;
      ts_d          = ts_q;
      frame_count_d = frame_count_q;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               opcode_d   = reqOpcode;
               ts_d       = reqTimestamp;
               byte_idx_d = 2'd0;
               state_d    = ST_SOF;
            end
         end
         ST_SOF: begin
            if (xfer) begin
               state_d = ST_DATA;
            end
         end
         ST_DATA: begin
            // Index wraps 3 -> 0 on the last byte, ready for the next frame.
            if (xfer) begin
               byte_idx_d = byte_idx_q + 2'd1;
               if (byte_idx_q == 2'd3) begin
                  state_d = ST_EOF;
               end
            end
         end
         ST_EOF: begin
            if (xfer) begin
               frame_count_d = frame_count_q + 16'd1;
               gap_cnt_d     = 4'd0;
               state_d       = (GAP_CYCLES > 0) ? ST_GAP : ST_IDLE;
            end
         end
         ST_GAP: begin
            if (gap_cnt_q == GAP_LAST) begin
               state_d = ST_IDLE;
            end else begin
               gap_cnt_d = gap_cnt_q + 4'd1;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge sysClk200) begin
      if (sysClk200Rst) begin
         state_q       <= ST_IDLE;
         byte_idx_q    <= 2'd0;
         gap_cnt_q     <= 4'd0;
         opcode_q      <= '0;
         ts_q          <= '0;
         frame_count_q <= 16'd0;
      end else begin
         state_q       <= state_d;
         byte_idx_q    <= byte_idx_d;
         gap_cnt_q     <= gap_cnt_d;
         opcode_q      <= opcode_d;
         ts_q          <= ts_d;
         frame_count_q <= frame_count_d;
      end
   end

endmodule

// File: tb/tb_cob_timing_tx.sv
// Directed bench for cob_timing_tx: one instance with a 2-cycle gap, one with no gap,
// each compared cycle by cycle against hand-built expected word streams.
module tb_cob_timing_tx;
   import cob_timing_pkg::*;

   logic        clock = 1'b0;
   logic        reset;

   logic        reqValidA, reqReadyA, txDataEnA, txReadyA, busyA;
   logic [7:0]  reqOpcodeA;
   logic [31:0] reqTimestampA;
   logic [9:0]  txDataA;
   logic [15:0] frameCountA;

   logic        reqValidB, reqReadyB, txDataEnB, txReadyB, busyB;
   logic [7:0]  reqOpcodeB;
   logic [31:0] reqTimestampB;
   logic [9:0]  txDataB;
   logic [15:0] frameCountB;

   int checkCount = 0;
   int errCount   = 0;

   logic       expEn[$];
   logic [9:0] expData[$];
   logic       expRdy[$];
   logic       planReady[$];

   always #5 clock = ~clock;

   cob_timing_tx #(.GAP_CYCLES(2)) dutGap2 (
      .sysClk200(clock), .sysClk200Rst(reset),
      .reqValid(reqValidA), .reqReady(reqReadyA),
      .reqOpcode(reqOpcodeA), .reqTimestamp(reqTimestampA),
      .txData(txDataA), .txDataEn(txDataEnA), .txReady(txReadyA),
      .busy(busyA), .frameCount(frameCountA)
   );

   cob_timing_tx #(.GAP_CYCLES(0)) dutGap0 (
      .sysClk200(clock), .sysClk200Rst(reset),
      .reqValid(reqValidB), .reqReady(reqReadyB),
      .reqOpcode(reqOpcodeB), .reqTimestamp(reqTimestampB),
      .txData(txDataB), .txDataEn(txDataEnB), .txReady(txReadyB),
      .busy(busyB), .frameCount(frameCountB)
   );

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errCount++;
         $display("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   task automatic pushCycle(input logic en, input logic [9:0] data, input logic rdy, input logic txr);
      expEn.push_back(en);
      expData.push_back(data);
      expRdy.push_back(rdy);
      planReady.push_back(txr);
   endtask

   // Expected frame from the word format; stallLen cycles of txReady=0 while word stallWord is shown.
   task automatic pushFrame(input logic [7:0] op, input logic [31:0] ts, input int stallWord, input int stallLen);
      logic [9:0] words [6];
      logic [7:0] chk;
      chk      = op ^ ts[31:24] ^ ts[23:16] ^ ts[15:8] ^ ts[7:0];
      words[0] = {2'b01, op};
      words[1] = {2'b00, ts[31:24]};
      words[2] = {2'b00, ts[23:16]};
      words[3] = {2'b00, ts[15:8]};
      words[4] = {2'b00, ts[7:0]};
      words[5] = {2'b10, chk};
      for (int w = 0; w < 6; w++) begin
         if (w == stallWord) begin
            for (int s = 0; s < stallLen; s++) pushCycle(1'b1, words[w], 1'b0, 1'b0);
         end
         pushCycle(1'b1, words[w], 1'b0, 1'b1);
      end
   endtask

   // Called at a negedge; compares each queued cycle, then drives txReady for that cycle.
   task automatic observeCycles(input string tag, input bit useGap0);
      logic       en;
      logic [9:0] data;
      logic       rdy;
      for (int i = 0; i < expEn.size(); i++) begin
         en   = useGap0 ? txDataEnB : txDataEnA;
         data = useGap0 ? txDataB   : txDataA;
         rdy  = useGap0 ? reqReadyB : reqReadyA;
         checkOutput($sformatf("%s en[%0d]", tag, i),   32'(en),   32'(expEn[i]));
         checkOutput($sformatf("%s data[%0d]", tag, i), 32'(data), 32'(expData[i]));
         checkOutput($sformatf("%s rdy[%0d]", tag, i),  32'(rdy),  32'(expRdy[i]));
         if (useGap0) txReadyB = planReady[i];
         else         txReadyA = planReady[i];
         @(negedge clock);
      end
      expEn.delete();
      expData.delete();
      expRdy.delete();
      planReady.delete();
   endtask

   // Presents a request and returns at the negedge of the cycle after acceptance (SOF cycle).
   task automatic applyStimulus(input string tag, input bit useGap0, input logic [7:0] op, input logic [31:0] ts);
      int waitCycles = 0;
      if (useGap0) begin
         reqValidB = 1'b1; reqOpcodeB = op; reqTimestampB = ts;
      end else begin
         reqValidA = 1'b1; reqOpcodeA = op; reqTimestampA = ts;
      end
      while (!(useGap0 ? reqReadyB : reqReadyA) && waitCycles < 20) begin
         @(negedge clock);
         waitCycles++;
      end
      checkOutput({tag, " accept"}, 32'(useGap0 ? reqReadyB : reqReadyA), 32'd1);
      @(negedge clock);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "[TB] simulation watchdog expired");
   end

   initial begin
      reset = 1'b1;
      reqValidA = 1'b0; reqOpcodeA = '0; reqTimestampA = '0; txReadyA = 1'b1;
      reqValidB = 1'b0; reqOpcodeB = '0; reqTimestampB = '0; txReadyB = 1'b1;

      @(negedge clock);
      checkOutput("rst reqReady", 32'(reqReadyA), 32'd0);
      checkOutput("rst txDataEn", 32'(txDataEnA), 32'd0);
      checkOutput("rst txData", 32'(txDataA), 32'd0);
      checkOutput("rst busy", 32'(busyA), 32'd0);
      checkOutput("rst frameCount", 32'(frameCountA), 32'd0);
      checkOutput("rst reqReady gap0", 32'(reqReadyB), 32'd0);
      reset = 1'b0;
      @(negedge clock);
      checkOutput("post-rst reqReady", 32'(reqReadyA), 32'd1);

      // Basic frame with literal expected words
      applyStimulus("basic", 1'b0, 8'hA5, 32'h12345678);
      reqValidA = 1'b0;
      pushCycle(1'b1, 10'h1A5, 1'b0, 1'b1);
      pushCycle(1'b1, 10'h012, 1'b0, 1'b1);
      pushCycle(1'b1, 10'h034, 1'b0, 1'b1);
      pushCycle(1'b1, 10'h056, 1'b0, 1'b1);
      pushCycle(1'b1, 10'h078, 1'b0, 1'b1);
      pushCycle(1'b1, 10'h2AD, 1'b0, 1'b1);
      pushCycle(1'b0, 10'h000, 1'b0, 1'b1);
      observeCycles("basic", 1'b0);
      checkOutput("basic frameCount", 32'(frameCountA), 32'd1);
      checkOutput("basic busy in gap", 32'(busyA), 32'd1);
      @(negedge clock);
      checkOutput("basic idle busy", 32'(busyA), 32'd0);

      // Stall for 3 cycles while the first DATA word is presented
      applyStimulus("stall", 1'b0, 8'hA5, 32'h12345678);
      reqValidA = 1'b0;
      pushFrame(8'hA5, 32'h12345678, 1, 3);
      pushCycle(1'b0, 10'h000, 1'b0, 1'b1);
      pushCycle(1'b0, 10'h000, 1'b0, 1'b1);
      pushCycle(1'b0, 10'h000, 1'b1, 1'b1);
      observeCycles("stall", 1'b0);
      checkOutput("stall frameCount", 32'(frameCountA), 32'd2);

      // Back-to-back: second request held during frame 1, gap of 2 plus 1 idle
      applyStimulus("b2b", 1'b0, 8'h11, 32'hDEADBEEF);
      reqOpcodeA = 8'h22;
      reqTimestampA = 32'h0BADF00D;
      pushFrame(8'h11, 32'hDEADBEEF, -1, 0);
      pushCycle(1'b0, 10'h000, 1'b0, 1'b1);
      pushCycle(1'b0, 10'h000, 1'b0, 1'b1);
      pushCycle(1'b0, 10'h000, 1'b1, 1'b1);
      pushFrame(8'h22, 32'h0BADF00D, -1, 0);
      observeCycles("b2b", 1'b0);
      reqValidA = 1'b0;
      @(negedge clock);
      @(negedge clock);
      checkOutput("b2b frameCount", 32'(frameCountA), 32'd4);
      checkOutput("b2b idle reqReady", 32'(reqReadyA), 32'd1);

      // frameCount wrap from 0xFFFF
      force dutGap2.frame_count_q = 16'hFFFF;
      @(negedge clock);
      @(negedge clock);
      release dutGap2.frame_count_q;
      @(negedge clock);
      checkOutput("wrap preload", 32'(frameCountA), 32'h0000FFFF);
      applyStimulus("wrap", 1'b0, 8'h5A, 32'h01020304);
      reqValidA = 1'b0;
      pushFrame(8'h5A, 32'h01020304, -1, 0);
      pushCycle(1'b0, 10'h000, 1'b0, 1'b1);
      observeCycles("wrap", 1'b0);
      checkOutput("wrap frameCount", 32'(frameCountA), 32'd0);
      @(negedge clock);

      // Reset while the third DATA word is presented
      applyStimulus("abort", 1'b0, 8'h3C, 32'hAABBCCDD);
      reqValidA = 1'b0;
      pushCycle(1'b1, 10'h13C, 1'b0, 1'b1);
      pushCycle(1'b1, 10'h0AA, 1'b0, 1'b1);
      pushCycle(1'b1, 10'h0BB, 1'b0, 1'b1);
      observeCycles("abort", 1'b0);
      checkOutput("abort 3rd data", 32'(txDataA), 32'h0CC);
      reset = 1'b1;
      @(negedge clock);
      checkOutput("abort txDataEn", 32'(txDataEnA), 32'd0);
      checkOutput("abort txData", 32'(txDataA), 32'd0);
      checkOutput("abort frameCount", 32'(frameCountA), 32'd0);
      checkOutput("abort reqReady in rst", 32'(reqReadyA), 32'd0);
      reset = 1'b0;
      @(negedge clock);
      checkOutput("abort reqReady after", 32'(reqReadyA), 32'd1);
      for (int i = 0; i < 3; i++) begin
         checkOutput($sformatf("abort no eof[%0d]", i), 32'(txDataEnA), 32'd0);
         @(negedge clock);
      end
      checkOutput("abort frameCount later", 32'(frameCountA), 32'd0);

      // Zero gap, all-zero payload, request held across two frames
      applyStimulus("gap0", 1'b1, 8'h00, 32'h00000000);
      pushCycle(1'b1, 10'h100, 1'b0, 1'b1);
      pushCycle(1'b1, 10'h000, 1'b0, 1'b1);
      pushCycle(1'b1, 10'h000, 1'b0, 1'b1);
      pushCycle(1'b1, 10'h000, 1'b0, 1'b1);
      pushCycle(1'b1, 10'h000, 1'b0, 1'b1);
      pushCycle(1'b1, 10'h200, 1'b0, 1'b1);
      pushCycle(1'b0, 10'h000, 1'b1, 1'b1);
      pushFrame(8'h00, 32'h00000000, -1, 0);
      observeCycles("gap0", 1'b1);
      reqValidB = 1'b0;
      checkOutput("gap0 frameCount", 32'(frameCountB), 32'd2);
      checkOutput("gap0 busy", 32'(busyB), 32'd0);
      @(negedge clock);
      checkOutput("gap0 no third", 32'(txDataEnB), 32'd0);

      $display("Result: errors=%0d of %0d checks", errCount, checkCount);
      $finish;
   end

endmodule
